// File: rtl/nn_weight_update_pkg.sv
// Shared types and helpers for the stochastic weight-update block:
// LFSR tap masks, the update FSM state type and the saturating descent step.
package nn_weight_update_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        APPLY = 1'b1
    } wuState_e;

    // Fibonacci feedback masks for maximal-length LFSRs (bit n-1 set for tap n).
    function automatic logic [31:0] lfsrTaps(input int width);
        logic [31:0] mask;
        case (width)
            4:       mask = 32'h0000_000C;
            5:       mask = 32'h0000_0014;
            6:       mask = 32'h0000_0030;
            7:       mask = 32'h0000_0060;
            8:       mask = 32'h0000_00B8;
            9:       mask = 32'h0000_0110;
            10:      mask = 32'h0000_0240;
            12:      mask = 32'h0000_0829;
            16:      mask = 32'h0000_D008;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

    // Signed w - step, clamped to the symmetric range a sign-magnitude weight can hold.
    function automatic int satSub(input int w, input int step, input int maxMag);
        int r;
        r = w - step;
        if (r > maxMag) begin
            r = maxMag;
        end else if (r < -maxMag) begin
            r = -maxMag;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_weight_update_if.sv
// Stream/control bundle between the weight-update node and its neighbours.
interface nn_weight_update_if #(
    parameter int WIDTH = 8
);
    logic             en_i;
    logic             load_i;
    logic [WIDTH-1:0] wInit_i;
    logic             wInitSign_i;
    logic             deltaIn_i;
    logic             signIn_i;
    logic             actIn_i;
    logic             alphaOut_o;
    logic             signW_o;
    logic [WIDTH-1:0] wMag_o;
    logic             update_o;

    modport master (
        output en_i, load_i, wInit_i, wInitSign_i, deltaIn_i, signIn_i, actIn_i,
        input  alphaOut_o, signW_o, wMag_o, update_o
    );

    modport slave (
        input  en_i, load_i, wInit_i, wInitSign_i, deltaIn_i, signIn_i, actIn_i,
        output alphaOut_o, signW_o, wMag_o, update_o
    );

endinterface

// File: rtl/nn_weight_update_ss_sng.sv
// Stochastic number generator: free-running maximal LFSR compared against a
// magnitude, giving exactly mag_i ones per LFSR period.
module nn_weight_update_ss_sng
    import nn_weight_update_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 'h5A
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] mag_i,
    output logic             bit_o
);

    localparam logic [31:0] TAP_MASK = lfsrTaps(WIDTH);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic             bit_q;

    // Shift left and feed the XOR of the tapped bits back into bit 0.
    always_comb begin
        lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAP_MASK[WIDTH-1:0])};
    end

    // LFSR advances every cycle; the comparison result is registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
            bit_q  <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            bit_q  <= (lfsr_q <= mag_i);
        end
    end

    assign bit_o = bit_q;

endmodule

// File: rtl/nn_weight_update.sv
// Weight-update node: correlates the back-propagated delta stream with the
// input activation over a fixed window, takes a descent step on a
// sign-magnitude weight at each window end, and re-emits the weight as a stream.
module nn_weight_update
    import nn_weight_update_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               WIN_BITS = 4,
    parameter int               SHIFT    = 0,
    parameter logic [WIDTH-1:0] SEED     = 'h5A
) (
    input logic               clk,
    input logic               rst_n,
    nn_weight_update_if.slave bus
);

    localparam int ACC_W   = WIN_BITS + 2;
    localparam int MAX_MAG = (1 << WIDTH) - 1;
    localparam logic signed [ACC_W-1:0] ACC_ONE = 1;

    wuState_e                 state_q;
    wuState_e                 state_d;
    logic [WIN_BITS-1:0]      cnt_q;
    logic [WIN_BITS-1:0]      cnt_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [WIDTH-1:0]         wMag_q;
    logic [WIDTH-1:0]         wMag_d;
    logic                     wSign_q;
    logic                     wSign_d;
    logic                     signW_q;
    logic                     windowEnd;
    logic                     grad;
    logic signed [ACC_W-1:0]  step;
    int                       wCur;
    int                       wNext;
    int                       wAbs;

    // A window closes on the enabled cycle in which the counter wraps.
    always_comb begin
        grad      = bus.deltaIn_i & bus.actIn_i;
        windowEnd = (state_q == ACCUM) && bus.en_i && (cnt_q == '1);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: LOAD always returns to accumulation, APPLY lasts one cycle.
    always_comb begin
        state_d = state_q;
        if (bus.load_i) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   state_d = windowEnd ? APPLY : ACCUM;
                APPLY:   state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // FSM output: UPDATE marks the apply cycle unless a load pre-empts it.
    always_comb begin
        bus.update_o = (state_q == APPLY) && !bus.load_i;
    end

    // Descent step on the signed weight with saturation to the magnitude range.
    always_comb begin
        step  = acc_q >>> SHIFT;
        wCur  = wSign_q ? -int'(wMag_q) : int'(wMag_q);
        wNext = satSub(wCur, int'(step), MAX_MAG);
        wAbs  = (wNext < 0) ? -wNext : wNext;
    end

    // Datapath next state: load beats apply, apply beats accumulation.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wMag_d  = wMag_q;
        wSign_d = wSign_q;
        if (bus.load_i) begin
            wMag_d  = bus.wInit_i;
            wSign_d = bus.wInitSign_i && (bus.wInit_i != '0);
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == APPLY) begin
            wMag_d  = WIDTH'(wAbs);
            wSign_d = (wNext < 0);
            acc_d   = '0;
        end else if (bus.en_i) begin
            cnt_d = cnt_q + WIN_BITS'(1);
            if (grad && !bus.signIn_i) begin
                acc_d = acc_q + ACC_ONE;
            end else if (grad && bus.signIn_i) begin
                acc_d = acc_q - ACC_ONE;
            end
        end
    end

    // Datapath registers, plus the sign pipelined to line up with the stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            wMag_q  <= '0;
            wSign_q <= 1'b0;
            signW_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wMag_q  <= wMag_d;
            wSign_q <= wSign_d;
            signW_q <= wSign_q;
        end
    end

    nn_weight_update_ss_sng #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_sng (
        .clk   (clk),
        .rst_n (rst_n),
        .mag_i (wMag_q),
        .bit_o (bus.alphaOut_o)
    );

    assign bus.wMag_o  = wMag_q;
    assign bus.signW_o = signW_q;

endmodule
